modulo_controlador_rolhas: RTL and testbench
============================================

MODULO_CONTROLADOR_ROLHAS -- requirements
Module: modulo_controlador_rolhas

Interface
REQ-001 The block SHALL have parameter REFILL_QTY, default 15, meaning corks added per refill.
REQ-002 The block SHALL have parameter MAX_CORKS, default 99, meaning the magazine capacity and saturation value.
REQ-003 The block SHALL have parameter LOW_THRESH, default 5, meaning low_stock asserts when cork_count <= this value.
REQ-004 The block SHALL have parameter SEAL_TIMEOUT, default 8, meaning the maximum number of SEAL cycles allowed without seal_done.
REQ-005 The block SHALL use one clock and an asynchronous active-low reset: clk input 1, rising-edge system clock.
REQ-006 rst_n input 1: asynchronous active-low reset.
REQ-007 start input 1: level input; 1 = production enabled.
REQ-008 bottle_at_station input 1: bottle positioned under the sealer.
REQ-009 seal_done input 1: single-cycle pulse from the sealer indicating a cork was inserted.
REQ-010 refill_req input 1: single-cycle pulse requesting a magazine refill.
REQ-011 fault_clr input 1: operator acknowledge for a timeout fault.
REQ-012 cork_count output 7: binary cork stock 0..MAX_CORKS, which drives the tens/units digit encoders.
REQ-013 sealed_count output 7: bottles sealed, modulo 100.
REQ-014 conveyor_en, sealer_en, refilling, low_stock, empty_alarm, timeout_alarm outputs 1 each: actuator enables and status flags.
REQ-015 state output 3: current FSM encoding for the display/debug.

Function
REQ-016 The FSM SHALL have states IDLE=0, RUN=1, SEAL=2, EMPTY=3, REFILL=4, FAULT=5; codes 6-7 SHALL return to IDLE on the next clock.
REQ-017 In IDLE: if refill_req=1, go to REFILL; else if start=1 and cork_count>0, go to RUN; else if start=1 and cork_count=0, go to EMPTY.
REQ-018 In RUN: conveyor_en=1; if start=0, go to IDLE; else if bottle_at_station=1, go to SEAL and clear the timer.
REQ-019 In SEAL: sealer_en=1, conveyor_en=0, and the 4-bit timer increments each cycle.
REQ-020 In SEAL on seal_done=1: decrement cork_count, increment sealed_count (99 wraps to 0), then go to EMPTY if the new count is 0, IDLE if start=0, otherwise RUN.
REQ-021 In SEAL, if timer = SEAL_TIMEOUT-1 and seal_done=0, go to FAULT; if seal_done and the timeout coincide, seal_done SHALL win.
REQ-022 In SEAL, start=0 SHALL be ignored until the seal completes or times out.
REQ-023 In EMPTY: empty_alarm=1; refill_req=1 goes to REFILL; start is ignored.
REQ-024 REFILL SHALL last exactly one cycle with refilling=1, set cork_count = min(cork_count+REFILL_QTY, MAX_CORKS), then go to IDLE.
REQ-025 Arithmetic SHALL use an 8-bit intermediate so the saturation comparison cannot overflow.
REQ-026 refill_req SHALL be ignored in RUN, SEAL and FAULT (no pending request is stored).
REQ-027 In FAULT: timeout_alarm=1 and all actuators are off; fault_clr=1 goes to IDLE; the cork count is unchanged.
REQ-028 low_stock SHALL be combinational: (cork_count <= LOW_THRESH), including the value 0.
REQ-029 All other status outputs SHALL be a combinational decode of the registered state, with zero added latency.
REQ-030 cork_count SHALL never go below 0; a decrement at 0 is impossible by construction because SEAL is unreachable with 0 corks.

Reset
REQ-031 When rst_n=0, the block SHALL asynchronously force: state=IDLE, cork_count=0, sealed_count=0, timer=0.
REQ-032 Under reset, the outputs SHALL be conveyor_en=0, sealer_en=0, refilling=0, empty_alarm=0, timeout_alarm=0, and low_stock=1.
REQ-033 Reset asserted mid-SEAL or mid-REFILL SHALL abort the operation with no count update.
REQ-034 Release SHALL be synchronized to clk so the first transition occurs no earlier than the second rising edge after deassertion.

Verification
REQ-035 Reset, refill_req pulse -> REFILL for 1 cycle, cork_count=15, low_stock=0, state back to IDLE.
REQ-036 Seven refills -> cork_count saturates at 99; an eighth refill keeps 99.
REQ-037 cork_count=1, start=1, bottle_at_station=1, seal_done in cycle 3 of SEAL -> cork_count=0, sealed_count=1, state=EMPTY, empty_alarm=1.
REQ-038 SEAL with no seal_done for 8 cycles -> FAULT, timeout_alarm=1, conveyor/sealer off; fault_clr -> IDLE, count unchanged.
REQ-039 seal_done coincident with the timeout cycle -> decrement taken, no FAULT.
REQ-040 sealed_count at 99 plus one seal -> 0; refill_req during RUN -> no count change.

Source files
------------

// File: rtl/modulo_controlador_rolhas.sv
// rtl/modulo_controlador_rolhas.sv - cork magazine / sealing station controller
module modulo_controlador_rolhas #(
    parameter int REFILL_QTY   = 15,
    parameter int MAX_CORKS    = 99,
    parameter int LOW_THRESH   = 5,
    parameter int SEAL_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       bottle_at_station,
    input  logic       seal_done,
    input  logic       refill_req,
    input  logic       fault_clr,
    output logic [6:0] cork_count,
    output logic [6:0] sealed_count,
    output logic       conveyor_en,
    output logic       sealer_en,
    output logic       refilling,
    output logic       low_stock,
    output logic       empty_alarm,
    output logic       timeout_alarm,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        SEAL   = 3'd2,
        EMPTY  = 3'd3,
        REFILL = 3'd4,
        FAULT  = 3'd5
    } state_t;

    localparam logic [7:0] REFILL8   = 8'(REFILL_QTY);
    localparam logic [7:0] MAX8      = 8'(MAX_CORKS);
    localparam logic [7:0] LOW8      = 8'(LOW_THRESH);
    localparam logic [3:0] TIMER_END = 4'(SEAL_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [6:0] cork_q, cork_d;
    logic [6:0] sealed_q, sealed_d;
    logic [3:0] timer_q, timer_d;
    logic [7:0] refill_sum;
    logic [1:0] rst_sync;
    logic       run_en;

    // Reset asserts immediately but releases two clocks later, so the FSM
    // never sees a partial edge right after deassertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run_en = rst_sync[1];

    always_comb begin
        state_d    = state_q;
        cork_d     = cork_q;
        sealed_d   = sealed_q;
        timer_d    = timer_q;
        refill_sum = {1'b0, cork_q} + REFILL8;
        case (state_q)
            IDLE: begin
                if (refill_req) begin
                    state_d = REFILL;
                end else if (start && (cork_q != 7'd0)) begin
                    state_d = RUN;
                end else if (start) begin
                    state_d = EMPTY;
                end
            end
            RUN: begin
                if (!start) begin
                    state_d = IDLE;
                end else if (bottle_at_station) begin
                    state_d = SEAL;
                    timer_d = 4'd0;
                end
            end
            SEAL: begin
                timer_d = timer_q + 4'd1;
                // seal_done has priority over the timeout in the same cycle
                if (seal_done) begin
                    cork_d   = cork_q - 7'd1;
                    sealed_d = (sealed_q == 7'd99) ? 7'd0 : sealed_q + 7'd1;
                    if (cork_q == 7'd1) begin
                        state_d = EMPTY;
                    end else if (!start) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RUN;
                    end
                end else if (timer_q == TIMER_END) begin
                    state_d = FAULT;
                end
            end
            EMPTY: begin
                if (refill_req) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                cork_d  = (refill_sum > MAX8) ? MAX8[6:0] : refill_sum[6:0];
                state_d = IDLE;
            end
            FAULT: begin
                if (fault_clr) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cork_q   <= 7'd0;
            sealed_q <= 7'd0;
            timer_q  <= 4'd0;
        end else if (!run_en) begin
            state_q  <= IDLE;
            cork_q   <= 7'd0;
            sealed_q <= 7'd0;
            timer_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            cork_q   <= cork_d;
            sealed_q <= sealed_d;
            timer_q  <= timer_d;
        end
    end

    assign state         = state_q;
    assign cork_count    = cork_q;
    assign sealed_count  = sealed_q;
    assign conveyor_en   = (state_q == RUN);
    assign sealer_en     = (state_q == SEAL);
    assign refilling     = (state_q == REFILL);
    assign empty_alarm   = (state_q == EMPTY);
    assign timeout_alarm = (state_q == FAULT);
    assign low_stock     = ({1'b0, cork_q} <= LOW8);

endmodule

// File: tb/tb_modulo_controlador_rolhas.sv
// tb/tb_modulo_controlador_rolhas.sv - randomized + directed bench with behavioural model
module tb_modulo_controlador_rolhas;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       bottle_at_station = 1'b0;
    logic       seal_done = 1'b0;
    logic       refill_req = 1'b0;
    logic       fault_clr = 1'b0;
    logic [6:0] cork_count;
    logic [6:0] sealed_count;
    logic       conveyor_en, sealer_en, refilling, low_stock, empty_alarm, timeout_alarm;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    modulo_controlador_rolhas dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bottle_at_station(bottle_at_station),
        .seal_done(seal_done), .refill_req(refill_req), .fault_clr(fault_clr),
        .cork_count(cork_count), .sealed_count(sealed_count), .conveyor_en(conveyor_en),
        .sealer_en(sealer_en), .refilling(refilling), .low_stock(low_stock),
        .empty_alarm(empty_alarm), .timeout_alarm(timeout_alarm), .state(state)
    );

    always #5 clk = ~clk;

    // Model: phase number, stock, sealed bottles, SEAL cycles elapsed, clocks since release
    int m_phase = 0;
    int m_cork = 0;
    int m_sealed = 0;
    int m_seal_cycles = 0;
    int m_settle = 0;

    task automatic m_reset();
        m_phase = 0; m_cork = 0; m_sealed = 0; m_seal_cycles = 0; m_settle = 0;
    endtask

    task automatic m_step();
        case (m_phase)
            0: begin
                if (refill_req) m_phase = 4;
                else if (start && m_cork > 0) m_phase = 1;
                else if (start) m_phase = 3;
            end
            1: begin
                if (!start) m_phase = 0;
                else if (bottle_at_station) begin m_phase = 2; m_seal_cycles = 0; end
            end
            2: begin
                m_seal_cycles++;
                if (seal_done) begin
                    m_cork   = m_cork - 1;
                    m_sealed = (m_sealed + 1) % 100;
                    if (m_cork == 0) m_phase = 3;
                    else if (!start) m_phase = 0;
                    else m_phase = 1;
                end else if (m_seal_cycles == 8) m_phase = 5;
            end
            3: if (refill_req) m_phase = 4;
            4: begin
                m_cork  = (m_cork + 15 > 99) ? 99 : m_cork + 15;
                m_phase = 0;
            end
            5: if (fault_clr) m_phase = 0;
            default: m_phase = 0;
        endcase
    endtask

    always @(posedge clk) begin
        if (!rst_n) m_reset();
        else if (m_settle < 2) m_settle++;
        else m_step();
    end

    always @(negedge rst_n) m_reset();

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", 32'(state), 32'(m_phase));
            chk("cork_count", 32'(cork_count), 32'(m_cork));
            chk("sealed_count", 32'(sealed_count), 32'(m_sealed));
            chk("conveyor_en", 32'(conveyor_en), 32'(m_phase == 1));
            chk("sealer_en", 32'(sealer_en), 32'(m_phase == 2));
            chk("refilling", 32'(refilling), 32'(m_phase == 4));
            chk("empty_alarm", 32'(empty_alarm), 32'(m_phase == 3));
            chk("timeout_alarm", 32'(timeout_alarm), 32'(m_phase == 5));
            chk("low_stock", 32'(low_stock), 32'(m_cork <= 5));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_refill();
        refill_req = 1'b1; tick(); refill_req = 1'b0; tick();
    endtask

    // From RUN with start=1: present a bottle, wait n SEAL cycles, then seal
    task automatic do_seal(input int n_wait);
        bottle_at_station = 1'b1; tick(); bottle_at_station = 1'b0;
        repeat (n_wait) tick();
        seal_done = 1'b1; tick(); seal_done = 1'b0;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        repeat (2) tick();
        chk_en = 1'b1;
        chk("reset_state", 32'(state), 0);
        chk("reset_cork", 32'(cork_count), 0);
        chk("reset_low_stock", 32'(low_stock), 1);
        chk("reset_actuators", 32'({conveyor_en, sealer_en, refilling, empty_alarm, timeout_alarm}), 0);
        release_reset();

        refill_req = 1'b1; tick(); refill_req = 1'b0;
        chk("refill_state", 32'(state), 4);
        chk("refilling_flag", 32'(refilling), 1);
        tick();
        chk("refill1_cork", 32'(cork_count), 15);
        chk("refill1_low", 32'(low_stock), 0);
        chk("refill1_idle", 32'(state), 0);

        repeat (6) pulse_refill();
        chk("refill7_sat", 32'(cork_count), 99);
        pulse_refill();
        chk("refill8_sat", 32'(cork_count), 99);

        start = 1'b1; tick();
        for (int i = 0; i < 98; i++) do_seal(0);
        chk("after98_cork", 32'(cork_count), 1);
        chk("after98_sealed", 32'(sealed_count), 98);

        do_seal(2);
        chk("last_cork", 32'(cork_count), 0);
        chk("last_sealed", 32'(sealed_count), 99);
        chk("last_empty", 32'(state), 3);
        chk("last_alarm", 32'(empty_alarm), 1);
        tick();
        chk("empty_ignores_start", 32'(state), 3);

        pulse_refill();
        tick();
        chk("run_after_refill", 32'(state), 1);
        refill_req = 1'b1; tick(); refill_req = 1'b0;
        chk("refill_ignored_run", 32'(cork_count), 15);
        do_seal(0);
        chk("sealed_wrap", 32'(sealed_count), 0);
        chk("wrap_cork", 32'(cork_count), 14);

        bottle_at_station = 1'b1; tick(); bottle_at_station = 1'b0;
        start = 1'b0;
        repeat (7) tick();
        chk("seal_holds_start0", 32'(state), 2);
        tick();
        chk("timeout_fault", 32'(state), 5);
        chk("timeout_alarm", 32'(timeout_alarm), 1);
        chk("fault_actuators_off", 32'({conveyor_en, sealer_en}), 0);
        refill_req = 1'b1; tick(); refill_req = 1'b0;
        chk("fault_ignores_refill", 32'(state), 5);
        fault_clr = 1'b1; tick(); fault_clr = 1'b0;
        chk("fault_clr_idle", 32'(state), 0);
        chk("fault_cork_kept", 32'(cork_count), 14);

        start = 1'b1; tick();
        do_seal(7);
        chk("coincident_no_fault", 32'(state), 1);
        chk("coincident_cork", 32'(cork_count), 13);

        bottle_at_station = 1'b1; tick(); bottle_at_station = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        chk("midseal_reset_cork", 32'(cork_count), 0);
        start = 1'b0;
        release_reset();

        for (int c = 0; c < 4000; c++) begin
            start             = ($urandom_range(0, 9) < 8);
            bottle_at_station = $urandom_range(0, 1) == 1;
            seal_done         = ($urandom_range(0, 9) < 3);
            refill_req        = ($urandom_range(0, 9) == 0);
            fault_clr         = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
